// File: rtl/ipsxe_fft_pingpong_buf_pkg.sv
// Shared definitions for the FFT ping-pong frame buffer: frame depth helper,
// address bit-reversal and the bank index type.
package ipsxe_fft_pp_pkg;

    // One bit selects between the two banks.
    typedef logic bank_idx_t;

    localparam bank_idx_t BANK0 = 1'b0;
    localparam bank_idx_t BANK1 = 1'b1;

    // Widest address the bit-reversal helper handles.
    localparam int MAX_ADDR_WIDTH = 10;

    // Frame length in samples for a given address width.
    function automatic int depth_of(input int aw);
        return 32'sd1 << aw;
    endfunction

    // Reverse the low 'width' bits of addr; the bits above stay zero.
    function automatic logic [MAX_ADDR_WIDTH-1:0] bitrev(
        input logic [MAX_ADDR_WIDTH-1:0] addr,
        input int                        width
    );
        logic [MAX_ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
            if (i < width) begin
                r[i] = addr[width-1-i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ipsxe_fft_pingpong_buf_if.sv
// Streaming interface of the ping-pong buffer: the input (s_*) and output (m_*)
// valid/ready channels. The buffer uses the slave view, the surrounding
// producer/consumer uses the master view.
interface ipsxe_fft_pingpong_buf_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHAN_NUM   = 2
) ();
    logic                           s_valid;
    logic                           s_ready;
    logic [CHAN_NUM*DATA_WIDTH-1:0] s_data;
    logic                           s_last;
    logic                           m_valid;
    logic                           m_ready;
    logic [CHAN_NUM*DATA_WIDTH-1:0] m_data;
    logic                           m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ipsxe_fft_pingpong_buf_bank.sv
// One distributed-RAM bank of the ping-pong buffer: synchronous write,
// asynchronous read. Contents are never reset.
module ipsxe_fft_pp_bank
    import ipsxe_fft_pp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the incoming sample on a write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ipsxe_fft_pingpong_buf.sv
// Two-bank ping-pong frame buffer for the FFT datapath. The writer fills one
// bank with a DEPTH-sample frame while the reader drains the other through a
// registered output stage. s_last is only checked against the frame counter.
// Build option: define IPSXE_FFT_PP_BITREV_EN to store samples at the
// bit-reversed write address so bit-reversed input leaves in natural order.
module ipsxe_fft_pingpong_buf
    import ipsxe_fft_pp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CHAN_NUM   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    ipsxe_fft_pingpong_buf_if.slave    bus,
    output logic [1:0]                 bank_full,
    output logic                       frame_err
);
    localparam int W = CHAN_NUM * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            bank_full_r;
    logic [1:0]            bank_full_nxt_s;
    bank_idx_t             wr_bank_r;
    bank_idx_t             rd_bank_r;
    logic [ADDR_WIDTH-1:0] wr_cnt_r;
    logic [ADDR_WIDTH-1:0] rd_cnt_r;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic                  s_ready_s;
    logic                  accept_s;
    logic                  wr_close_s;
    logic                  advance_s;
    logic                  load_s;
    logic                  rd_free_s;
    logic                  we0_s;
    logic                  we1_s;
    logic [W-1:0]          rdata0_s;
    logic [W-1:0]          rdata1_s;
    logic [W-1:0]          rdata_s;
    logic [W-1:0]          m_data_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic                  frame_err_r;

    assign s_ready_s  = ~bank_full_r[wr_bank_r];
    assign accept_s   = bus.s_valid & s_ready_s;
    assign wr_close_s = accept_s & (wr_cnt_r == CNT_LAST);
    assign advance_s  = ~m_valid_r | bus.m_ready;
    assign load_s     = advance_s & bank_full_r[rd_bank_r];
    assign rd_free_s  = load_s & (rd_cnt_r == CNT_LAST);
    assign we0_s      = accept_s & (wr_bank_r == BANK0);
    assign we1_s      = accept_s & (wr_bank_r == BANK1);

`ifdef IPSXE_FFT_PP_BITREV_EN
    logic [MAX_ADDR_WIDTH-1:0] wr_ext_s;
    logic [MAX_ADDR_WIDTH-1:0] wr_rev_s;

    // Bit-reverse the write counter so reversed input is stored in natural order.
    always_comb begin
        wr_ext_s                 = {MAX_ADDR_WIDTH{1'b0}};
        wr_ext_s[ADDR_WIDTH-1:0] = wr_cnt_r;
        wr_rev_s                 = bitrev(wr_ext_s, ADDR_WIDTH);
        waddr_s                  = wr_rev_s[ADDR_WIDTH-1:0];
    end
`else
    // Identity ordering: samples land at their arrival index.
    always_comb begin
        waddr_s = wr_cnt_r;
    end
`endif

    ipsxe_fft_pp_bank #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(W)) u_bank0 (
        .clk   (clk),
        .we    (we0_s),
        .waddr (waddr_s),
        .wdata (bus.s_data),
        .raddr (rd_cnt_r),
        .rdata (rdata0_s)
    );

    ipsxe_fft_pp_bank #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(W)) u_bank1 (
        .clk   (clk),
        .we    (we1_s),
        .waddr (waddr_s),
        .wdata (bus.s_data),
        .raddr (rd_cnt_r),
        .rdata (rdata1_s)
    );

    // Select the asynchronous read data of the bank being drained.
    always_comb begin
        case (rd_bank_r)
            BANK0:   rdata_s = rdata0_s;
            BANK1:   rdata_s = rdata1_s;
            default: rdata_s = {W{1'b0}};
        endcase
    end

    // Merge the writer's close and the reader's free; they never hit the same bank.
    always_comb begin
        bank_full_nxt_s = bank_full_r;
        if (wr_close_s) begin
            bank_full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            bank_full_nxt_s[wr_bank_r] = bank_full_r[wr_bank_r];
        end
        if (rd_free_s) begin
            bank_full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            bank_full_nxt_s[rd_bank_r] = bank_full_nxt_s[rd_bank_r];
        end
    end

    // Bank full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_r <= 2'b00;
        end else begin
            bank_full_r <= bank_full_nxt_s;
        end
    end

    // Write side: frame counter, bank pointer and the s_last consistency check.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r    <= {ADDR_WIDTH{1'b0}};
            wr_bank_r   <= BANK0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= accept_s & (bus.s_last != (wr_cnt_r == CNT_LAST));
            if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
            if (wr_close_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
        end
    end

    // Read side: output register, read counter and bank pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_r  <= {W{1'b0}};
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            rd_cnt_r  <= {ADDR_WIDTH{1'b0}};
            rd_bank_r <= BANK0;
        end else if (advance_s) begin
            if (load_s) begin
                m_data_r  <= rdata_s;
                m_valid_r <= 1'b1;
                m_last_r  <= (rd_cnt_r == CNT_LAST);
                rd_cnt_r  <= rd_cnt_r + CNT_ONE;
                if (rd_free_s) begin
                    rd_bank_r <= ~rd_bank_r;
                end
            end else begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_last  = m_last_r;
    assign bank_full   = bank_full_r;
    assign frame_err   = frame_err_r;

endmodule
